// File: rtl/countdown_timer_if.sv
// Control, load-value and display signals of the countdown timer.
// master drives the controls (prescaler/keypad side); slave is the timer itself.
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [3:0] ld_min_t;
    logic [3:0] ld_min_o;
    logic [3:0] ld_sec_t;
    logic [3:0] ld_sec_o;
    logic       start;
    logic       stop;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output tick, load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, stop,
        input  min_t, min_o, sec_t, sec_o, running, done, expired
    );

    modport slave (
        input  tick, load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, stop,
        output min_t, min_o, sec_t, sec_o, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD mm:ss down-counter driven by the 1 Hz tick; all outputs registered, one-cycle input-to-output latency.
// No backpressure; `COUNTDOWN_AUTO_RELOAD_EN` reloads from a shadow copy at 00:00 instead of stopping in DONE.
module countdown_timer #(
    parameter int MAX_MIN = 99
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } bcd_t;

    localparam logic [3:0] MAX_T   = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O   = 4'(MAX_MIN % 10);
    localparam logic [6:0] MAX_VAL = 7'(MAX_MIN);

    state_t state_q, state_d;
    bcd_t   cnt_q, cnt_d;
    logic   expired_q, expired_d;
    bcd_t   ld_val;
    bcd_t   dec_val;
    logic   cnt_zero;
    logic   dec_zero;
    logic   go;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic bcd_t dec_bcd(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.sec_o != 4'd0) begin
            r.sec_o = v.sec_o - 4'd1;
        end else begin
            r.sec_o = 4'd9;
            if (v.sec_t != 4'd0) begin
                r.sec_t = v.sec_t - 4'd1;
            end else begin
                r.sec_t = 4'd5;
                if (v.min_o != 4'd0) begin
                    r.min_o = v.min_o - 4'd1;
                end else begin
                    r.min_o = 4'd9;
                    r.min_t = v.min_t - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Sanitise the load digits: BCD range, seconds tens <= 5, then clamp minutes.
    always_comb begin
        logic [6:0] min_val;
        ld_val.min_t = clamp9(tmr.ld_min_t);
        ld_val.min_o = clamp9(tmr.ld_min_o);
        ld_val.sec_o = clamp9(tmr.ld_sec_o);
        ld_val.sec_t = (tmr.ld_sec_t > 4'd5) ? 4'd5 : tmr.ld_sec_t;
        min_val = 7'(ld_val.min_t) * 7'd10 + 7'(ld_val.min_o);
        if (min_val > MAX_VAL) begin
            ld_val.min_t = MAX_T;
            ld_val.min_o = MAX_O;
        end
    end

    assign cnt_zero = (cnt_q == '0);
    assign dec_val  = dec_bcd(cnt_q);
    assign dec_zero = (dec_val == '0);
    assign go       = tmr.start && !tmr.stop && !cnt_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_t shadow_q, shadow_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (tmr.load && state_q != RUN) begin
            shadow_d = ld_val;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        if (tmr.load && state_q != RUN) begin
            state_d = IDLE;
            cnt_d   = ld_val;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (go) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tmr.stop) begin
                        state_d = PAUSE;
                    end
                    if (tmr.tick && !cnt_zero) begin
                        cnt_d = dec_val;
                        if (dec_zero) begin
                            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            // Skip the 00:00 display; an empty shadow cannot restart.
                            if (shadow_q != '0) begin
                                cnt_d = shadow_q;
                            end else begin
                                state_d = IDLE;
                            end
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tmr.min_t   = cnt_q.min_t;
    assign tmr.min_o   = cnt_q.min_o;
    assign tmr.sec_t   = cnt_q.sec_t;
    assign tmr.sec_o   = cnt_q.sec_o;
    assign tmr.running = (state_q == RUN);
    assign tmr.expired = expired_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign tmr.done    = 1'b0;
`else
    assign tmr.done    = (state_q == DONE);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with MAX_MIN=20; digits compared as a packed 16-bit BCD word.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    countdown_timer_if tif ();

    countdown_timer #(.MAX_MIN(20)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned digits();
        return {16'h0, tif.min_t, tif.min_o, tif.sec_t, tif.sec_o};
    endfunction

    function automatic int unsigned bcd_of(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {16'h0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Outputs are read 1 ns after the edge that consumed the inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mo,
                           input logic [3:0] st, input logic [3:0] so);
        tif.load = 1'b1;
        tif.ld_min_t = mt;
        tif.ld_min_o = mo;
        tif.ld_sec_t = st;
        tif.ld_sec_o = so;
        cyc();
        tif.load = 1'b0;
    endtask

    task automatic pulse_start();
        tif.start = 1'b1;
        cyc();
        tif.start = 1'b0;
    endtask

    task automatic pulse_tick();
        tif.tick = 1'b1;
        cyc();
        tif.tick = 1'b0;
    endtask

    initial begin
        tif.tick = 1'b0;
        tif.load = 1'b0;
        tif.start = 1'b0;
        tif.stop = 1'b0;
        tif.ld_min_t = 4'd0;
        tif.ld_min_o = 4'd0;
        tif.ld_sec_t = 4'd0;
        tif.ld_sec_o = 4'd0;
        reset = 1'b1;
        cyc();
        chk("rst_digits", digits(), 32'h0000);
        chk("rst_running", 32'(tif.running), 0);
        chk("rst_done", 32'(tif.done), 0);
        chk("rst_expired", 32'(tif.expired), 0);
        reset = 1'b0;
        cyc();

        // 01:05 run down to expiry
        do_load(4'd0, 4'd1, 4'd0, 4'd5);
        chk("ld_0105", digits(), 32'h0105);
        chk("ld_running", 32'(tif.running), 0);
        pulse_start();
        chk("start_running", 32'(tif.running), 1);
        for (int i = 1; i <= 65; i++) begin
            pulse_tick();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            chk($sformatf("run_t%0d", i), digits(), (i == 65) ? 32'h0105 : bcd_of(65 - i));
`else
            chk($sformatf("run_t%0d", i), digits(), bcd_of(65 - i));
`endif
            chk($sformatf("exp_t%0d", i), 32'(tif.expired), (i == 65) ? 1 : 0);
        end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk("done_set", 32'(tif.done), 1);
        chk("done_running", 32'(tif.running), 0);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            chk("done_hold", digits(), 32'h0000);
            chk("done_no_exp", 32'(tif.expired), 0);
        end
`endif
        tif.stop = 1'b1;
        cyc();
        tif.stop = 1'b0;

        // load sanitising with MAX_MIN=20
        do_load(4'd1, 4'd2, 4'd9, 4'd12);
        chk("san_1259", digits(), 32'h1259);
        chk("san_done_clr", 32'(tif.done), 0);
        do_load(4'd9, 4'd9, 4'd0, 4'd0);
        chk("san_clamp20", digits(), 32'h2000);
        do_load(4'd1, 4'd15, 4'd7, 4'd3);
        chk("san_1953", digits(), 32'h1953);

        // pause via stop+tick, ticks discarded while paused
        do_load(4'd0, 4'd0, 4'd1, 4'd0);
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            chk("p_run", digits(), bcd_of(10 - i));
        end
        tif.tick = 1'b1;
        tif.stop = 1'b1;
        cyc();
        tif.tick = 1'b0;
        tif.stop = 1'b0;
        chk("p_stop_tick", digits(), 32'h0006);
        chk("p_paused", 32'(tif.running), 0);
        for (int i = 0; i < 5; i++) pulse_tick();
        chk("p_hold", digits(), 32'h0006);
        pulse_start();
        chk("p_resume", 32'(tif.running), 1);
        tif.stop = 1'b1;
        cyc();
        tif.start = 1'b1;
        cyc();
        tif.stop = 1'b0;
        tif.start = 1'b0;
        chk("p_start_stop", 32'(tif.running), 0);
        chk("p_start_stop_d", digits(), 32'h0006);

        // load+start in IDLE, start at 00:00, load during RUN
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        tif.start = 1'b1;
        do_load(4'd0, 4'd2, 4'd3, 4'd0);
        tif.start = 1'b0;
        chk("ls_digits", digits(), 32'h0230);
        chk("ls_running", 32'(tif.running), 0);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        pulse_start();
        chk("zero_start", 32'(tif.running), 0);
        do_load(4'd0, 4'd3, 4'd2, 4'd8);
        pulse_start();
        pulse_tick();
        chk("run_0327", digits(), 32'h0327);
        do_load(4'd0, 4'd5, 4'd0, 4'd0);
        chk("run_ld_ign", digits(), 32'h0327);
        chk("run_ld_state", 32'(tif.running), 1);

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("arst_digits", digits(), 32'h0000);
        chk("arst_running", 32'(tif.running), 0);
        cyc();
        reset = 1'b0;
        cyc();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            pulse_tick();
            chk("ar_digits", digits(), (i % 2 == 1) ? 32'h0001 : 32'h0002);
            chk("ar_expired", 32'(tif.expired), (i % 2 == 0) ? 1 : 0);
            chk("ar_running", 32'(tif.running), 1);
            chk("ar_done", 32'(tif.done), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
